// File: rtl/vend_pkg.sv
// Shared definitions for the vending front end: coin encodings, credit FSM states
// and the default product prices also used by vending_controller.
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_5C   = 2'b00,
      COIN_10C  = 2'b01,
      COIN_25C  = 2'b10,
      COIN_100C = 2'b11
   } coin_type_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_DEDUCT = 2'd2,
      ST_REFUND = 2'd3
   } state_t;

   localparam int UNITS_5C   = 1;
   localparam int UNITS_10C  = 2;
   localparam int UNITS_25C  = 5;
   localparam int UNITS_100C = 20;

   localparam int PRICE1_DEFAULT = 10;
   localparam int PRICE2_DEFAULT = 15;

   // Value of a coin in 5-cent units.
   function automatic logic [4:0] coin_units(input logic [1:0] ct);
      logic [4:0] u;
      case (ct)
         COIN_5C:  u = 5'(UNITS_5C);
         COIN_10C: u = 5'(UNITS_10C);
         COIN_25C: u = 5'(UNITS_25C);
         default:  u = 5'(UNITS_100C);
      endcase
      return u;
   endfunction

endpackage

// File: rtl/coin_credit_unit_coin_sync.sv
// Brings the asynchronous coin strobe into the clk domain and flags its rising edge,
// with coin_type captured as the strobe passes the first synchronizer stage.
module coin_sync
   import vend_pkg::*;
(
   input  logic       clk,
   input  logic       rnot,
   input  logic       coin_in,
   input  logic [1:0] coin_type,
   output logic       coin_edge,
   output logic [1:0] coin_type_cap
);

   logic       sync1_reg;
   logic       sync2_reg;
   logic       hist_reg;
   logic [1:0] type_reg;

   always_ff @(posedge clk) begin
      if (!rnot) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         hist_reg  <= 1'b0;
         type_reg  <= 2'b00;
      end else begin
         sync1_reg <= coin_in;
         sync2_reg <= sync1_reg;
         hist_reg  <= sync2_reg;
         // coin_in has already been seen high once here, so coin_type is settled
         if (sync1_reg && !sync2_reg) begin
            type_reg <= coin_type;
         end
      end
   end

   assign coin_edge     = sync2_reg & ~hist_reg;
   assign coin_type_cap = type_reg;

endmodule

// File: rtl/coin_credit_unit.sv
// Credit front end for vending_controller: accumulates coins, deducts vend prices,
// pays leftover credit back as spaced change pulses and drives the credit thermometer.
module coin_credit_unit
   import vend_pkg::*;
#(
   parameter int CREDIT_W   = 8,
   parameter int MAX_CREDIT = 40,
   parameter int TH0        = 5,
   parameter int TH1        = 10,
   parameter int TH2        = 15,
   parameter int TH3        = 20,
   parameter int PRICE1     = PRICE1_DEFAULT,
   parameter int PRICE2     = PRICE2_DEFAULT,
   parameter int CHANGE_GAP = 4
) (
   input  logic                clk,
   input  logic                rnot,
   input  logic                coin_in,
   input  logic [1:0]          coin_type,
   input  logic                cancel,
   input  logic                product1,
   input  logic                product2,
   output logic [3:0]          i,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                change_pulse,
   output logic                busy
);

   localparam int CW    = CREDIT_W + 1;
   localparam int GAP_W = $clog2(CHANGE_GAP);
   localparam int TH_TABLE [0:3] = '{TH0, TH1, TH2, TH3};

   state_t              state_reg, state_next;
   logic [CREDIT_W-1:0] credit_reg, credit_next;
   logic                price_sel_reg, price_sel_next;
   logic                coin_reject_reg, coin_reject_next;
   logic [GAP_W-1:0]    gap_reg, gap_next;
   logic                p1_d_reg, p2_d_reg;
   logic                p1_edge_reg, p2_edge_reg;

   logic                coin_edge;
   logic [1:0]          coin_type_cap;
   logic                vend_edge;
   logic [CW-1:0]       credit_ext;
   logic [CW-1:0]       coin_value;
   logic [CW-1:0]       credit_sum;
   logic [CW-1:0]       price;
   logic [CW-1:0]       deducted;

   coin_sync u_coin_sync (
      .clk           (clk),
      .rnot          (rnot),
      .coin_in       (coin_in),
      .coin_type     (coin_type),
      .coin_edge     (coin_edge),
      .coin_type_cap (coin_type_cap)
   );

   always_ff @(posedge clk) begin
      if (!rnot) begin
         p1_d_reg    <= 1'b0;
         p2_d_reg    <= 1'b0;
         p1_edge_reg <= 1'b0;
         p2_edge_reg <= 1'b0;
      end else begin
         p1_d_reg    <= product1;
         p2_d_reg    <= product2;
         p1_edge_reg <= product1 & ~p1_d_reg;
         p2_edge_reg <= product2 & ~p2_d_reg;
      end
   end

   assign vend_edge  = p1_edge_reg | p2_edge_reg;
   assign credit_ext = {1'b0, credit_reg};
   assign coin_value = CW'(coin_units(coin_type_cap));
   assign credit_sum = credit_ext + coin_value;
   assign price      = price_sel_reg ? CW'(PRICE2) : CW'(PRICE1);
   assign deducted   = (credit_ext > price) ? (credit_ext - price) : '0;

   always_ff @(posedge clk) begin
      if (!rnot) begin
         state_reg       <= ST_IDLE;
         credit_reg      <= '0;
         price_sel_reg   <= 1'b0;
         coin_reject_reg <= 1'b0;
         gap_reg         <= '0;
      end else begin
         state_reg       <= state_next;
         credit_reg      <= credit_next;
         price_sel_reg   <= price_sel_next;
         coin_reject_reg <= coin_reject_next;
         gap_reg         <= gap_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      credit_next      = credit_reg;
      price_sel_next   = price_sel_reg;
      coin_reject_next = 1'b0;
      gap_next         = '0;
      change_pulse     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (coin_edge) begin
               if (cancel || vend_edge || (coin_value > CW'(MAX_CREDIT))) begin
                  coin_reject_next = 1'b1;
               end else begin
                  credit_next = coin_value[CREDIT_W-1:0];
                  state_next  = ST_ACCUM;
               end
            end
         end
         ST_ACCUM: begin
            if (cancel) begin
               state_next       = ST_REFUND;
               coin_reject_next = coin_edge;
            end else if (vend_edge) begin
               // product1 wins when both vend edges land together
               state_next       = ST_DEDUCT;
               price_sel_next   = ~p1_edge_reg;
               coin_reject_next = coin_edge;
            end else if (coin_edge) begin
               if (credit_sum <= CW'(MAX_CREDIT)) begin
                  credit_next = credit_sum[CREDIT_W-1:0];
               end else begin
                  coin_reject_next = 1'b1;
               end
            end
         end
         ST_DEDUCT: begin
            coin_reject_next = coin_edge;
            credit_next      = deducted[CREDIT_W-1:0];
            state_next       = (deducted != '0) ? ST_REFUND : ST_IDLE;
         end
         ST_REFUND: begin
            coin_reject_next = coin_edge;
            if (credit_reg == '0) begin
               state_next = ST_IDLE;
            end else if (gap_reg == '0) begin
               change_pulse = 1'b1;
               credit_next  = credit_reg - 1'b1;
               gap_next     = GAP_W'(CHANGE_GAP - 1);
               if (credit_reg == CREDIT_W'(1)) begin
                  state_next = ST_IDLE;
               end
            end else begin
               gap_next = gap_reg - 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Thermometer follows the credit register directly, no extra latency.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_therm
         assign i[gi] = (credit_reg >= CREDIT_W'(TH_TABLE[gi]));
      end
   endgenerate

   assign credit      = credit_reg;
   assign coin_reject = coin_reject_reg;
   assign busy        = (state_reg == ST_DEDUCT) || (state_reg == ST_REFUND);

endmodule

// File: tb/tb_coin_credit_unit.sv
// Self-checking bench for coin_credit_unit: table-driven coin vectors, hand-built
// multi-cycle corner cases and randomized scenarios scored by a transaction-level model.
module tb_coin_credit_unit;

   localparam int MAXC = 40;
   localparam int GAP  = 4;
   localparam int P1   = 10;
   localparam int P2   = 15;

   logic       clk = 1'b0;
   logic       rnot;
   logic       coin_in;
   logic [1:0] coin_type;
   logic       cancel;
   logic       product1;
   logic       product2;
   logic [3:0] i;
   logic [7:0] credit;
   logic       coin_reject;
   logic       change_pulse;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   int model_credit = 0;

   typedef struct {
      logic [1:0] ct;
      int         exp_credit;
      logic [3:0] exp_i;
      bit         exp_rej;
   } vec_t;

   vec_t tbl [9];

   coin_credit_unit dut (
      .clk          (clk),
      .rnot         (rnot),
      .coin_in      (coin_in),
      .coin_type    (coin_type),
      .cancel       (cancel),
      .product1     (product1),
      .product2     (product2),
      .i            (i),
      .credit       (credit),
      .coin_reject  (coin_reject),
      .change_pulse (change_pulse),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int units(input logic [1:0] t);
      case (t)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 5;
         default: return 20;
      endcase
   endfunction

   function automatic logic [3:0] therm(input int c);
      return {c >= 20, c >= 15, c >= 10, c >= 5};
   endfunction

   // One coin: credit must hold for two edges and change on the third.
   task automatic coin_txn(input logic [1:0] t, input int exp_c, input bit exp_rej, input string nm);
      int old_c;
      old_c     = model_credit;
      coin_type = t;
      coin_in   = 1'b1;
      tick();
      tick();
      check({nm, "_hold"}, credit, old_c);
      check({nm, "_rej_early"}, coin_reject, 0);
      tick();
      check({nm, "_credit"}, credit, exp_c);
      check({nm, "_therm"}, i, therm(exp_c));
      check({nm, "_reject"}, coin_reject, exp_rej);
      tick();
      check({nm, "_rej_width"}, coin_reject, 0);
      coin_in = 1'b0;
      repeat (3) tick();
      model_credit = exp_c;
      $display("coin %s type=%0d credit=%0d reject=%0d", nm, t, credit, exp_rej);
   endtask

   // Watch a DEDUCT/REFUND episode until busy drops, then score it.
   task automatic run_refund(input int exp_first, input int exp_pulses, input string nm);
      int npulse = 0;
      int last = -1;
      int first_c = -1;
      bit gap_bad = 0;
      bit seen_busy = 0;
      bit done = 0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (busy) seen_busy = 1;
         if (change_pulse) begin
            if (npulse == 0) first_c = credit;
            else if (k - last != GAP) gap_bad = 1;
            last = k;
            npulse++;
         end
         if (seen_busy && !busy) done = 1;
      end
      check({nm, "_finished"}, done, 1);
      check({nm, "_pulses"}, npulse, exp_pulses);
      if (exp_pulses > 0) check({nm, "_first_credit"}, first_c, exp_first);
      check({nm, "_gap_err"}, gap_bad, 0);
      check({nm, "_end_credit"}, credit, 0);
      check({nm, "_end_therm"}, i, 0);
      model_credit = 0;
      $display("refund %s pulses=%0d first=%0d", nm, npulse, first_c);
   endtask

   task automatic do_cancel(input int exp, input string nm);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      run_refund(exp, exp, nm);
   endtask

   task automatic do_vend(input bit a, input bit b, input int exp, input string nm);
      product1 = a;
      product2 = b;
      run_refund(exp, exp, nm);
      product1 = 1'b0;
      product2 = 1'b0;
      repeat (2) tick();
   endtask

   task automatic random_scenario(input int s);
      int ncoin;
      int act;
      int after;
      ncoin = $urandom_range(1, 5);
      for (int c = 0; c < ncoin; c++) begin
         logic [1:0] t;
         int v;
         t = 2'($urandom_range(0, 3));
         v = units(t);
         if (model_credit == 0)               coin_txn(t, v, 0, "rnd");
         else if (model_credit + v <= MAXC)   coin_txn(t, model_credit + v, 0, "rnd");
         else                                 coin_txn(t, model_credit, 1, "rnd");
      end
      act = $urandom_range(0, 3);
      case (act)
         0: do_cancel(model_credit, "rnd_cancel");
         1: begin after = (model_credit > P1) ? model_credit - P1 : 0; do_vend(1, 0, after, "rnd_p1"); end
         2: begin after = (model_credit > P2) ? model_credit - P2 : 0; do_vend(0, 1, after, "rnd_p2"); end
         default: begin after = (model_credit > P1) ? model_credit - P1 : 0; do_vend(1, 1, after, "rnd_both"); end
      endcase
      $display("scenario %0d action=%0d", s, act);
   endtask

   initial begin
      int npulse;
      bit got3;
      tbl[0] = '{2'b10,  5, 4'b0001, 1'b0};
      tbl[1] = '{2'b10, 10, 4'b0011, 1'b0};
      tbl[2] = '{2'b01, 12, 4'b0011, 1'b0};
      tbl[3] = '{2'b11, 32, 4'b1111, 1'b0};
      tbl[4] = '{2'b10, 37, 4'b1111, 1'b0};
      tbl[5] = '{2'b00, 38, 4'b1111, 1'b0};
      tbl[6] = '{2'b10, 38, 4'b1111, 1'b1};
      tbl[7] = '{2'b01, 40, 4'b1111, 1'b0};
      tbl[8] = '{2'b00, 40, 4'b1111, 1'b1};

      rnot = 1'b0; coin_in = 1'b0; coin_type = 2'b10;
      cancel = 1'b0; product1 = 1'b0; product2 = 1'b0;

      // Reset with coin_in toggling.
      for (int k = 0; k < 3; k++) begin
         coin_in = ~coin_in;
         @(negedge clk);
         check("rst_credit", credit, 0);
         check("rst_therm", i, 0);
         check("rst_pulses", {coin_reject, change_pulse, busy}, 0);
      end
      @(posedge clk);
      #1;
      coin_in = 1'b0;
      rnot = 1'b1;
      repeat (4) tick();
      check("post_rst_credit", credit, 0);
      check("post_rst_reject", coin_reject, 0);
      $display("reset credit=%0d i=%b", credit, i);

      for (int r = 0; r < 9; r++) begin
         check("tbl_therm_model", therm(tbl[r].exp_credit), tbl[r].exp_i);
         coin_txn(tbl[r].ct, tbl[r].exp_credit, tbl[r].exp_rej, $sformatf("tbl%0d", r));
      end
      do_cancel(40, "cancel40");

      // Vend product1 at 12 -> 2 units of change.
      coin_txn(2'b10, 5, 0, "v1a");
      coin_txn(2'b10, 10, 0, "v1b");
      coin_txn(2'b01, 12, 0, "v1c");
      do_vend(1, 0, 2, "vend_p1");

      // Vend product2 at 12 clamps to zero: no change.
      coin_txn(2'b10, 5, 0, "v2a");
      coin_txn(2'b10, 10, 0, "v2b");
      coin_txn(2'b01, 12, 0, "v2c");
      do_vend(0, 1, 0, "vend_p2_clamp");

      // Cancel coincident with a coin edge at credit 7.
      coin_txn(2'b10, 5, 0, "colla");
      coin_txn(2'b01, 7, 0, "collb");
      coin_type = 2'b10;
      coin_in = 1'b1;
      tick();
      tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      coin_in = 1'b0;
      check("coll_reject", coin_reject, 1);
      check("coll_busy", busy, 1);
      run_refund(7, 7, "coll_refund");
      repeat (3) tick();

      // Reset after 3 of 7 change pulses.
      coin_txn(2'b10, 5, 0, "mra");
      coin_txn(2'b01, 7, 0, "mrb");
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      npulse = 0;
      got3 = 0;
      for (int k = 0; k < 60 && !got3; k++) begin
         @(negedge clk);
         if (change_pulse) npulse++;
         if (npulse == 3) got3 = 1;
      end
      check("mr_three_pulses", got3, 1);
      @(posedge clk);
      #1;
      rnot = 1'b0;
      tick();
      tick();
      rnot = 1'b1;
      npulse = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (change_pulse) npulse++;
      end
      check("mr_no_pulses", npulse, 0);
      check("mr_credit", credit, 0);
      check("mr_busy", busy, 0);
      model_credit = 0;
      $display("mid-refund reset credit=%0d busy=%0d", credit, busy);

      for (int s = 0; s < 25; s++) random_scenario(s);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
